run_length_meter: RTL and testbench
===================================

Name: run_length_meter

Overview:
Sits directly downstream of the glitch filter and takes the filter's cleaned `sig_out` as its `sig_in`.
- Measures the length of every stable high and low run, in clock cycles.
- Emits one record {level, length, saturated} per completed run through a small FIFO with a valid/ready handshake.
- Used to characterise the filtered serial pattern and for later decoding.

Parameters:
- CNT_W, 8: width of the run-length counter and of `rec_len`.
- FIFO_DEPTH, 4: number of records buffered. Must be a power of 2, minimum 2.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sig_in  in  1  filtered signal from the filter stage's `sig_out`.
- rec_valid  out  1  a record is available at the FIFO head.
- rec_ready  in  1  consumer accepts the head record this cycle.
- rec_level  out  1  level of the completed run.
- rec_len  out  CNT_W  run length in cycles, saturating.
- rec_sat  out  1  run exceeded 2^CNT_W-1 cycles.
- overflow  out  1  sticky: a record was dropped because the FIFO was full.

Behaviour:
- Reset: while `reset`=1 at a clock edge:
  - state<=SYNC; cnt<=0; prev<=0; FIFO emptied.
  - `rec_valid`, `rec_level`, `rec_len`, `rec_sat`, `overflow` all 0.
- A reset asserted mid-run discards the partial run and all buffered records. There is no partial record.
- FSM states SYNC, WAIT_EDGE, RUN:
  - SYNC (first cycle after reset): prev<=sig_in; go to WAIT_EDGE.
  - WAIT_EDGE: if sig_in!=prev, then prev<=sig_in, cnt<=1, sat<=0, go to RUN. Otherwise hold. The initial run has an unknown start, so it is never reported.
  - RUN, sig_in==prev: cnt<=cnt+1. If cnt is already all-ones, cnt holds and sat<=1.
  - RUN, sig_in!=prev (edge): push {prev, cnt, sat}; then prev<=sig_in, cnt<=1, sat<=0; stay in RUN.
- Length: the number of rising clock edges at which sig_in was sampled at that level. A 1-cycle pulse gives len=1.
- Latency: a record pushed at edge clock t gives `rec_valid`=1 at t+1 if the FIFO was empty.
- FIFO: synchronous, registered outputs, FIFO order.
  - Pop when rec_valid && rec_ready.
  - The `rec_*` outputs stay stable while rec_valid && !rec_ready.
- Full: a push while full and not popping in the same cycle is dropped, and overflow<=1 until reset.
  - Push and pop in the same cycle while full: both take effect; no drop.
  - Push and pop in the same cycle while holding exactly one record: the new record becomes the head the next cycle; `rec_valid` stays 1.
- Empty: `rec_ready` is ignored.
- Pointers wrap modulo FIFO_DEPTH. Full/empty is decided by an occupancy count of width log2(FIFO_DEPTH)+1.

Optional Feature:
- Macro: RUN_LENGTH_METER_EDGE_COUNT_EN.
- Defined: adds output `edge_count` [15:0].
  - Increments on every edge detected in WAIT_EDGE or RUN, including edges whose records were dropped.
  - Wraps from 16'hFFFF to 0; 0 on reset.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Decomposition:
- Package rlm_pkg holds:
  - the state enum {SYNC, WAIT_EDGE, RUN};
  - the record struct typedef {level, sat, len[CNT_W-1:0]};
  - localparam CNT_MAX.
- Sub-module rlm_fifo: a generic synchronous FIFO with WIDTH/DEPTH parameters, push/pop, full/empty and registered head. It is instantiated once.

Test Plan:
- Idle after reset: reset, then sig_in=0 for 20 cycles -> rec_valid stays 0, overflow=0.
- Single run: sig_in 0->1 at cycle 5, held high 6 cycles, then 0 -> exactly one record {level=1, len=6, sat=0}, with rec_valid rising 1 cycle after the falling-edge sample.
- Saturation (CNT_W=8): a 300-cycle high run, then an edge -> record {1, 255, sat=1}. The next 1-cycle low pulse gives {0, 1, 0}.
- Back-pressure and overflow (FIFO_DEPTH=4, rec_ready=0): six alternating runs of length 3 -> rec_valid=1, overflow=1, FIFO holds the first 4 records. Raising rec_ready then drains them in order, each {level alternating, len=3}, and rec_valid drops after the fourth.
- Full with simultaneous push/pop: FIFO full, rec_ready=1 on the same cycle as an edge -> no drop, overflow stays 0, occupancy stays 4.
- Reset mid-run: reset during a 10-cycle high run -> all outputs 0 the next cycle. After release, no record is produced until two further edges have occurred.

Source files
------------

// File: rtl/rlm_pkg.sv
// rlm_pkg: shared state encoding, record layout and length limit for run_length_meter
package rlm_pkg;
    localparam int LEN_W = 8;
    localparam logic [LEN_W-1:0] CNT_MAX = '1;
    typedef enum logic [1:0] {SYNC, WAIT_EDGE, RUN} state_t;
    typedef struct packed {
        logic             level;
        logic             sat;
        logic [LEN_W-1:0] len;
    } rec_t;
endpackage

// File: rtl/run_length_meter_fifo.sv
// rlm_fifo: synchronous FIFO with occupancy count and head taken straight from storage flops
module rlm_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_pop, do_push;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign dout  = mem_q[rd_q];
    // a push into a full FIFO is accepted only when the head leaves in the same cycle
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/run_length_meter.sv
// run_length_meter: measures high/low run lengths and queues one record per run (RUN_LENGTH_METER_EDGE_COUNT_EN adds edge_count)
module run_length_meter
    import rlm_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sig_in,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic             rec_level,
    output logic [CNT_W-1:0] rec_len,
    output logic             rec_sat,
`ifdef RUN_LENGTH_METER_EDGE_COUNT_EN
    output logic [15:0]      edge_count,
`endif
    output logic             overflow
);
    state_t state_q, state_d;
    logic prev_q, prev_d, sat_q, sat_d, ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic push, edge_det, full, empty;
    logic [CNT_W+1:0] din, dout;
    // the first run after reset has an unknown start, so only RUN pushes records
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        push     = 1'b0;
        edge_det = state_q != SYNC && sig_in != prev_q;
        din      = {prev_q, sat_q, cnt_q};
        if (state_q == SYNC) begin
            prev_d  = sig_in;
            state_d = WAIT_EDGE;
        end else if (edge_det) begin
            push    = state_q == RUN;
            prev_d  = sig_in;
            cnt_d   = CNT_W'(1);
            sat_d   = 1'b0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            sat_d = sat_q | (&cnt_q);
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end
        ovf_d = ovf_q | (push && full && !rec_ready);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SYNC;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
        end
    end
    rlm_fifo #(.WIDTH(CNT_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (din),
        .pop   (rec_ready),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );
    assign rec_valid = !empty;
    assign {rec_level, rec_sat, rec_len} = dout;
    assign overflow = ovf_q;
`ifdef RUN_LENGTH_METER_EDGE_COUNT_EN
    logic [15:0] edges_q, edges_d;
    always_comb edges_d = edges_q + 16'(edge_det);
    always_ff @(posedge clock) edges_q <= reset ? '0 : edges_d;
    assign edge_count = edges_q;
`endif
endmodule

// File: tb/tb_run_length_meter.sv
// tb_run_length_meter: scoreboard bench for run_length_meter with a per-cycle run model
module tb_run_length_meter;
    import rlm_pkg::*;
    localparam int DEPTH = 4;
    logic clock = 1'b0, reset = 1'b1, sig_in = 1'b0, rec_ready = 1'b0;
    logic rec_valid, rec_level, rec_sat, overflow;
    logic [LEN_W-1:0] rec_len;
`ifdef RUN_LENGTH_METER_EDGE_COUNT_EN
    logic [15:0] edge_count;
`endif
    run_length_meter #(.CNT_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .sig_in    (sig_in),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_level (rec_level),
        .rec_len   (rec_len),
        .rec_sat   (rec_sat),
`ifdef RUN_LENGTH_METER_EDGE_COUNT_EN
        .edge_count(edge_count),
`endif
        .overflow  (overflow)
    );
    always #5 clock = ~clock;

    int total = 0, bad = 0;
    rec_t exp_q[$];
    logic exp_ovf = 1'b0, m_level = 1'b0, m_started = 1'b0;
    int m_len = 0;
    logic [15:0] m_edges = '0;

    always @(negedge clock) begin
        if (!reset && rec_valid && rec_ready) begin
            rec_t got, want;
            got = '{level: rec_level, sat: rec_sat, len: rec_len};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %0h want none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL record: got lvl=%0b sat=%0b len=%0d want lvl=%0b sat=%0b len=%0d",
                             got.level, got.sat, got.len, want.level, want.sat, want.len);
                end
            end
        end
    end

    task automatic step(input logic v);
        rec_t r;
        if (v !== m_level) begin
            m_edges++;
            if (m_started) begin
                r.level = m_level;
                r.sat   = m_len > int'(CNT_MAX);
                r.len   = r.sat ? CNT_MAX : LEN_W'(m_len);
                if (exp_q.size() == DEPTH && !rec_ready) exp_ovf = 1'b1;
                else exp_q.push_back(r);
            end
            m_started = 1'b1;
            m_level   = v;
            m_len     = 1;
        end else m_len++;
        sig_in = v;
        @(posedge clock); #1;
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) step(v);
    endtask

    task automatic do_reset(input logic lvl);
        reset  = 1'b1;
        sig_in = lvl;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b0;
        exp_q.delete();
        exp_ovf   = 1'b0;
        m_level   = lvl;
        m_started = 1'b0;
        m_len     = 0;
        m_edges   = '0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        int seen;
        reset = 1'b1;
        @(posedge clock); #1;
        total++;
        if ({rec_valid, rec_level, rec_sat, overflow, rec_len} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %0h want 0", {rec_valid, rec_level, rec_sat, overflow, rec_len});
        end
        do_reset(1'b0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            seen += int'(rec_valid);
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL idle_valid: got %0d valid cycles want 0", seen); end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL idle_overflow: got %0b want 0", overflow); end
    endtask

    task automatic test_single_run();
        do_reset(1'b0);
        rec_ready = 1'b1;
        drive(1'b0, 4);
        drive(1'b1, 6);
        total++;
        if (rec_valid !== 1'b0) begin bad++; $display("FAIL single_pre_valid: got %0b want 0", rec_valid); end
        step(1'b0);
        total++;
        if (rec_valid !== 1'b1) begin bad++; $display("FAIL single_latency: got %0b want 1", rec_valid); end
        drive(1'b0, 3);
        total++;
        if (exp_q.size() !== 0 || rec_valid !== 1'b0)
            begin bad++; $display("FAIL single_drain: got pending=%0d valid=%0b want 0 0", exp_q.size(), rec_valid); end
    endtask

    task automatic test_saturation();
        rec_ready = 1'b1;
        drive(1'b1, 300);
        drive(1'b0, 1);
        drive(1'b1, 255);
        drive(1'b0, 256);
        drive(1'b1, 4);
        total++;
        if (exp_q.size() !== 0 || rec_valid !== 1'b0)
            begin bad++; $display("FAIL sat_drain: got pending=%0d valid=%0b want 0 0", exp_q.size(), rec_valid); end
    endtask

    task automatic test_overflow();
        do_reset(1'b0);
        rec_ready = 1'b0;
        repeat (3) begin drive(1'b1, 3); drive(1'b0, 3); end
        drive(1'b1, 3);
        total++;
        if (rec_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %0b want 1", rec_valid); end
        total++;
        if (overflow !== exp_ovf) begin bad++; $display("FAIL ovf_flag: got %0b want %0b", overflow, exp_ovf); end
`ifdef RUN_LENGTH_METER_EDGE_COUNT_EN
        total++;
        if (edge_count !== m_edges) begin bad++; $display("FAIL edge_count: got %0d want %0d", edge_count, m_edges); end
`endif
        rec_ready = 1'b1;
        drive(1'b1, 6);
        total++;
        if (exp_q.size() !== 0 || rec_valid !== 1'b0)
            begin bad++; $display("FAIL ovf_drain: got pending=%0d valid=%0b want 0 0", exp_q.size(), rec_valid); end
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    endtask

    task automatic test_mid_reset();
        rec_ready = 1'b0;
        drive(1'b0, 3);
        drive(1'b1, 5);
        total++;
        if (rec_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %0b want 1", rec_valid); end
        reset = 1'b1;
        @(posedge clock); #1;
        total++;
        if ({rec_valid, rec_level, rec_sat, overflow, rec_len} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %0h want 0", {rec_valid, rec_level, rec_sat, overflow, rec_len});
        end
        do_reset(1'b1);
        drive(1'b1, 3);
        drive(1'b0, 3);
        total++;
        if (rec_valid !== 1'b0) begin bad++; $display("FAIL mid_first_edge: got %0b want 0", rec_valid); end
        drive(1'b1, 3);
        total++;
        if (rec_valid !== 1'b1) begin bad++; $display("FAIL mid_second_edge: got %0b want 1", rec_valid); end
        rec_ready = 1'b1;
        drive(1'b1, 3);
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL mid_drain: got pending=%0d want 0", exp_q.size()); end
    endtask

    task automatic test_full_push_pop();
        do_reset(1'b0);
        rec_ready = 1'b0;
        repeat (2) begin drive(1'b1, 3); drive(1'b0, 3); end
        drive(1'b1, 3);
        total++;
        if (rec_valid !== 1'b1) begin bad++; $display("FAIL full_valid: got %0b want 1", rec_valid); end
        rec_ready = 1'b1;
        step(1'b0);
        rec_ready = 1'b0;
        drive(1'b0, 2);
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL full_no_drop: got %0b want 0", overflow); end
        rec_ready = 1'b1;
        drive(1'b0, 6);
        total++;
        if (exp_q.size() !== 0 || rec_valid !== 1'b0)
            begin bad++; $display("FAIL full_drain: got pending=%0d valid=%0b want 0 0", exp_q.size(), rec_valid); end
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_saturation();
        test_overflow();
        test_mid_reset();
        test_full_push_pop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
